// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared I-cache controller state encoding and line geometry helper
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    MEM_REQ = 3'd2,
    REFILL  = 3'd3,
    RESPOND = 3'd4
  } state_t;

  // Byte-offset width within one line; the tag/data arrays use the same split.
  function automatic int line_off_w(input int line_words, input int word_bytes);
    return $clog2(line_words * word_bytes);
  endfunction

endpackage

// File: rtl/refill_beat_counter.sv
// rtl/refill_beat_counter.sv - word index counter for in-order line refill beats
module refill_beat_counter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [$clog2(N)-1:0] idx,
  output logic                 last
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + W'(1);
    end
  end

  assign last = (idx == LAST_IDX);

endmodule

// File: rtl/icache_line_ctrl.sv
// rtl/icache_line_ctrl.sv - I-cache fetch controller: tag lookup, line-aligned miss request, refill, tag commit
module icache_line_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_req_valid,
  input  logic [ADDR_W-1:0]             cpu_req_addr,
  output logic                          cpu_req_ready,
  output logic                          cpu_resp_valid,
  output logic                          cpu_resp_err,
  input  logic                          hit,
  output logic [ADDR_W-1:0]             lookup_addr,
  output logic                          mem_req_valid,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_rdata_valid,
  input  logic                          mem_rdata_err,
  output logic                          refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
  output logic                          tag_we,
  output logic [2:0]                    state
);

  localparam int OFF_W = line_off_w(LINE_WORDS, WORD_BYTES);

  state_t state_q, state_d;
  logic   err_q;
  logic   beat_clr, beat_inc, beat_last;

  refill_beat_counter #(.N(LINE_WORDS)) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (beat_clr),
    .inc  (beat_inc),
    .idx  (refill_idx),
    .last (beat_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lookup_addr <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cpu_req_valid) begin
        lookup_addr <= cpu_req_addr;
        err_q       <= 1'b0;
      end
      if (state_q == REFILL && mem_rdata_valid && mem_rdata_err) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    refill_we = 1'b0;
    tag_we    = 1'b0;
    beat_clr  = 1'b0;
    beat_inc  = 1'b0;
    case (state_q)
      IDLE:    if (cpu_req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? RESPOND : MEM_REQ;
      MEM_REQ: begin
        if (mem_req_ready) begin
          beat_clr = 1'b1;
          state_d  = REFILL;
        end
      end
      REFILL: begin
        if (mem_rdata_valid) begin
          beat_inc = 1'b1;
          // An errored beat is never written and ends the burst, even on the last word.
          if (mem_rdata_err) begin
            state_d = RESPOND;
          end else begin
            refill_we = 1'b1;
            if (beat_last) begin
              tag_we  = 1'b1;
              state_d = RESPOND;
            end
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = (state_q == RESPOND);
  assign cpu_resp_err   = (state_q == RESPOND) && err_q;
  assign mem_req_valid  = (state_q == MEM_REQ);
  assign mem_req_addr   = {lookup_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign state          = state_q;

endmodule

// File: doc/icache_line_ctrl.md
# icache_line_ctrl

Parametrised I-cache request controller that replaces the single-beat hit/miss handler. It accepts one CPU fetch at a time and performs a tag lookup. On a miss it issues a line-aligned memory request, refills a LINE_WORDS-beat line into the data array, then commits the tag. The controller sits between the AHB slave front end, the tag/data arrays and the memory-side master, and reports errors on abort.

## Interface
- ADDR_W, 32, byte address width
- LINE_WORDS, 4, words per cache line; power of two, 2..64
- WORD_BYTES, 4, bytes per word; power of two
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req_valid  in  1  fetch request
- cpu_req_addr  in  ADDR_W  fetch byte address
- cpu_req_ready  out  1  request accepted when valid && ready
- cpu_resp_valid  out  1  one-cycle response pulse
- cpu_resp_err  out  1  response carries error; qualified by cpu_resp_valid
- hit  in  1  tag-array compare result for the latched address; sampled in LOOKUP only
- lookup_addr  out  ADDR_W  latched request address, drives tag/data array index
- mem_req_valid  out  1  line fetch request
- mem_req_addr  out  ADDR_W  lookup_addr with low log2(LINE_WORDS*WORD_BYTES) bits zeroed
- mem_req_ready  in  1  memory accepts request
- mem_rdata_valid  in  1  refill beat present
- mem_rdata_err  in  1  beat error; qualified by mem_rdata_valid
- refill_we  out  1  write current beat into data array
- refill_idx  out  $clog2(LINE_WORDS)  word index of current beat
- tag_we  out  1  commit tag + valid bit for lookup_addr
- state  out  3  current state (cache_pkg encoding)

## Operation
- States: IDLE, LOOKUP, MEM_REQ, REFILL, RESPOND.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid, latch cpu_req_addr into lookup_addr, clear err_q, go to LOOKUP.
- LOOKUP:
  - hit=1 goes to RESPOND.
  - hit=0 goes to MEM_REQ.
- MEM_REQ:
  - mem_req_valid=1, and mem_req_addr is held stable until mem_req_ready.
  - On mem_req_ready, clear the beat counter and go to REFILL.
- REFILL, on each cycle with mem_rdata_valid:
  - refill_we=1 and refill_idx=beat counter, in the same cycle (Mealy); the counter then increments.
  - Beats arrive in order 0..LINE_WORDS-1. Refill is not critical-word-first.
  - Last beat (counter==LINE_WORDS-1) without error: assert tag_we in the same cycle, go to RESPOND.
  - Any beat with mem_rdata_err=1: refill_we=0 and tag_we=0 for that beat, set err_q, go to RESPOND. Memory terminates the burst on error; the line stays invalid.
  - Error on the last beat: error wins, and no tag_we.
- RESPOND: cpu_resp_valid=1 and cpu_resp_err=err_q for exactly one cycle, then go to IDLE.
- All outputs except refill_we and tag_we are decoded from state or registers (Moore).
- Ignored inputs:
  - mem_rdata_valid outside REFILL is ignored.
  - mem_req_ready outside MEM_REQ is ignored.
  - hit outside LOOKUP is ignored.
- Beat counter width is $clog2(LINE_WORDS). It never wraps within one refill because exit occurs on the last beat.

## Timing
- Reset values:
  - state=IDLE and cpu_req_ready=1.
  - lookup_addr=0, so mem_req_addr=0.
  - All other outputs =0.
- Reset asserted mid-refill: return to IDLE immediately, with no tag_we and no response. Partially written data words remain, but the line stays invalid.
- Hit latency: request accepted in cycle 0, LOOKUP in cycle 1, cpu_resp_valid in cycle 2.
- Miss latency: 3 + request-wait cycles + beat cycles. Minimum is 3+LINE_WORDS+1 with zero wait states; mem_req_valid is first high in cycle 2.
- No back-to-back accept: the earliest next acceptance is the cycle after RESPOND.
- cpu_req_valid while not in IDLE: not accepted (ready=0); the requester holds the request.

## Structure
- cache_pkg:
  - state_t enum (IDLE=0, LOOKUP=1, MEM_REQ=2, REFILL=3, RESPOND=4).
  - Line-offset width function shared with the tag/data arrays.
- Sub-module refill_beat_counter:
  - Parameter N.
  - Ports: clr, inc, idx, last.
- The controller instantiates one refill_beat_counter.

## Test plan
- Reset, then request addr 0x0000_1004 with hit=1 in LOOKUP. Required: resp_valid in cycle 2, err=0, no mem_req_valid.
- Miss at 0x0000_1234 with LINE_WORDS=4 and mem_req_ready on the 3rd cycle. Required: mem_req_addr=0x0000_1230 held throughout; refill_idx 0,1,2,3 with refill_we; tag_we with beat 3; resp err=0.
- Beat 1 with mem_rdata_err=1. Required: refill_we only for beat 0, tag_we never asserted, cpu_resp_err=1.
- Gapped beats (valid 1,0,0,1,1,0,1). Required: refill_we only on the valid cycles, idx increments per valid beat.
- rst low during REFILL after 2 beats. Required: state=IDLE, every output at its reset value, no resp pulse. A subsequent request with hit=0 re-fetches the full line.
- LINE_WORDS=8 at 0x0000_103C. Required: mem_req_addr=0x0000_1020, 8 beats, idx 0..7.
